// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths plus data-memory arbiter types
// Contents:
//   DATA, ADDRESSWIDTH    : datapath word width and byte-address width
//   DEFAULT_STARVE_LIMIT  : default number of denied port-1 cycles before a forced grant
//   arb_state_t           : arbiter FSM state
//   dmem_req_t            : one requester's memory access {we, addr, wdata}
package mips_pkg;

    localparam int DATA                 = 32;
    localparam int ADDRESSWIDTH         = 32;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic {
        P0_PRIO  = 1'b0,
        P1_FORCE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                    we;
        logic [ADDRESSWIDTH-1:0] addr;
        logic [DATA-1:0]         wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signals of the data-memory arbiter
// Signals:
//   p0_*/p1_*  : req, we, addr, wdata from each requester; gnt, rvalid, rdata back to it
//   misalign_err : pulse after a granted access with addr[1:0] != 0
//   mem_*      : we, addr, wdata to the data memory; rdata (combinational) from it
// Modports:
//   master : requesters and memory side (drives requests and mem_rdata)
//   slave  : the arbiter
interface dmem_arbiter_if;
    import mips_pkg::*;

    logic                    p0_req;
    logic                    p0_we;
    logic [ADDRESSWIDTH-1:0] p0_addr;
    logic [DATA-1:0]         p0_wdata;
    logic                    p0_gnt;
    logic                    p0_rvalid;
    logic [DATA-1:0]         p0_rdata;

    logic                    p1_req;
    logic                    p1_we;
    logic [ADDRESSWIDTH-1:0] p1_addr;
    logic [DATA-1:0]         p1_wdata;
    logic                    p1_gnt;
    logic                    p1_rvalid;
    logic [DATA-1:0]         p1_rdata;

    logic                    misalign_err;

    logic                    mem_we;
    logic [ADDRESSWIDTH-1:0] mem_addr;
    logic [DATA-1:0]         mem_wdata;
    logic [DATA-1:0]         mem_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  misalign_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output misalign_err, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_starve_counter.sv
// rtl/dmem_starve_counter.sv - counts consecutive denied port-1 cycles and flags a forced grant
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req, gnt    : port-1 request and grant for the current cycle
//   limit       : denied cycles allowed before forcing (1..15)
//   force_next  : this cycle is the limit-th denial; next cycle must grant port 1
//   count       : current number of consecutive denials
module dmem_starve_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       gnt,
    input  logic [3:0] limit,
    output logic       force_next,
    output logic [3:0] count
);

    logic denied;

    assign denied     = req & ~gnt;
    assign force_next = denied & (count == 4'(limit - 4'd1));

    // The count restarts whenever port 1 is served, withdraws, or a force
    // is being scheduled, so each forced grant buys a full new window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (!denied || force_next) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the MEM stage and the loader port
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : dmem_arbiter_if.slave; port 0 (MEM stage, fixed priority), port 1
//                (loader/debug, starvation-protected), memory we/addr/wdata out,
//                memory rdata in, registered rdata/rvalid and misalign_err back
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    arb_state_t      state, state_next;
    logic            p0_gnt, p1_gnt, any_gnt;
    logic            force_next;
    logic [3:0]      starve_count;
    dmem_req_t       req0, req1, sel;
    logic            aligned;
    logic            p0_rvalid, p1_rvalid, misalign_err;
    logic [DATA-1:0] p0_rdata, p1_rdata;

    dmem_starve_counter u_starve (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.p1_req),
        .gnt        (p1_gnt),
        .limit      (4'(STARVE_LIMIT)),
        .force_next (force_next),
        .count      (starve_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= P0_PRIO;
        end else begin
            state <= state_next;
        end
    end

    // Grants are kept apart from next-state logic so the counter's
    // force_next (which depends on p1_gnt) does not form a comb loop.
    // Grants are held low during reset so no store can land.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            case (state)
                P0_PRIO: begin
                    p0_gnt = bus.p0_req;
                    p1_gnt = bus.p1_req & ~bus.p0_req;
                end
                P1_FORCE: begin
                    p1_gnt = bus.p1_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = P0_PRIO;
        if (state == P0_PRIO && force_next) begin
            state_next = P1_FORCE;
        end
    end

    assign any_gnt = p0_gnt | p1_gnt;

    // With no grant the mux rests on port 0, so mem_addr tracks the MEM stage.
    assign req0    = '{we: bus.p0_we, addr: bus.p0_addr, wdata: bus.p0_wdata};
    assign req1    = '{we: bus.p1_we, addr: bus.p1_addr, wdata: bus.p1_wdata};
    assign sel     = p1_gnt ? req1 : req0;
    assign aligned = (sel.addr[1:0] == 2'b00);

    assign bus.mem_we    = any_gnt & sel.we & aligned;
    assign bus.mem_addr  = sel.addr;
    assign bus.mem_wdata = sel.wdata;

    // Misaligned loads still return a (zero) response so the requester
    // never waits forever for rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rvalid    <= 1'b0;
            p1_rvalid    <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            misalign_err <= 1'b0;
        end else begin
            p0_rvalid    <= p0_gnt & ~bus.p0_we;
            p1_rvalid    <= p1_gnt & ~bus.p1_we;
            misalign_err <= any_gnt & ~aligned;
            if (p0_gnt && !bus.p0_we) begin
                p0_rdata <= aligned ? bus.mem_rdata : '0;
            end
            if (p1_gnt && !bus.p1_we) begin
                p1_rdata <= aligned ? bus.mem_rdata : '0;
            end
        end
    end

    assign bus.p0_gnt       = p0_gnt;
    assign bus.p1_gnt       = p1_gnt;
    assign bus.p0_rvalid    = p0_rvalid;
    assign bus.p1_rvalid    = p1_rvalid;
    assign bus.p0_rdata     = p0_rdata;
    assign bus.p1_rdata     = p1_rdata;
    assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural data memory: combinational read, write on rising edge.
    logic [DATA-1:0] mem [0:63] = '{default: '0};

    always_comb bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs sampled 2ns later.
    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
        #2;
    endtask

    initial begin
        reset = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 32'h4; bus.p0_wdata = 32'h0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
        repeat (2) @(posedge clk);

        // Reset values (requests held to prove grants are masked)
        drive(1, 1, 32'h8, 32'h1111_2222, 1, 0, 32'h0, 32'h0);
        check("rst_p0_gnt", 32'(bus.p0_gnt), 0);
        check("rst_p1_gnt", 32'(bus.p1_gnt), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 32'h8);
        check("rst_mem_wdata", bus.mem_wdata, 32'h1111_2222);
        check("rst_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 0);
        check("rst_rdata0", bus.p0_rdata, 0);
        check("rst_misalign", 32'(bus.misalign_err), 0);
        @(posedge clk); #1;
        check("rst_no_store", mem[2], 0);

        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;

        // Port-0 store then load
        drive(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
        check("st_p0_gnt", 32'(bus.p0_gnt), 1);
        check("st_mem_we", 32'(bus.mem_we), 1);
        check("st_mem_addr", bus.mem_addr, 32'h10);
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        check("ld_p0_gnt", 32'(bus.p0_gnt), 1);
        check("ld_mem_we", 32'(bus.mem_we), 0);
        check("st_no_rvalid", 32'(bus.p0_rvalid), 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("ld_p0_rvalid", 32'(bus.p0_rvalid), 1);
        check("ld_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
        check("ld_mem4", mem[4], 32'hDEAD_BEEF);

        // Idle port 0: port-1 store then load of 0x20
        drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h1234_5678);
        check("p1st_gnt", 32'(bus.p1_gnt), 1);
        check("p1st_mem_addr", bus.mem_addr, 32'h20);
        check("p0_rvalid_drop", 32'(bus.p0_rvalid), 0);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        check("p1ld_gnt", 32'(bus.p1_gnt), 1);
        check("p1ld_p0_gnt", 32'(bus.p0_gnt), 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("p1ld_rvalid", 32'(bus.p1_rvalid), 1);
        check("p1ld_rdata", bus.p1_rdata, 32'h1234_5678);
        check("p1ld_p0_rvalid", 32'(bus.p0_rvalid), 0);
        check("p0_rdata_hold", bus.p0_rdata, 32'hDEAD_BEEF);
        check("nogrant_mem_we", 32'(bus.mem_we), 0);

        // Starvation: both requesting, p1 forced on cycle 5
        for (int i = 1; i <= 6; i++) begin
            drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            check($sformatf("stv%0d_p0_gnt", i), 32'(bus.p0_gnt), (i == 5) ? 0 : 1);
            check($sformatf("stv%0d_p1_gnt", i), 32'(bus.p1_gnt), (i == 5) ? 1 : 0);
        end
        check("stv_p1_rvalid", 32'(bus.p1_rvalid), 1);
        check("stv_p0_rvalid", 32'(bus.p0_rvalid), 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("stv_p0_rvalid_back", 32'(bus.p0_rvalid), 1);

        // Misaligned store: granted, no write, error pulse
        drive(1, 1, 32'h13, 32'hCAFE_F00D, 0, 0, 32'h0, 32'h0);
        check("mis_st_gnt", 32'(bus.p0_gnt), 1);
        check("mis_st_mem_we", 32'(bus.mem_we), 0);
        drive(1, 0, 32'h11, 32'h0, 0, 0, 32'h0, 32'h0);
        check("mis_st_err", 32'(bus.misalign_err), 1);
        check("mis_st_no_rvalid", 32'(bus.p0_rvalid), 0);
        check("mis_st_mem4", mem[4], 32'hDEAD_BEEF);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("mis_ld_err", 32'(bus.misalign_err), 1);
        check("mis_ld_rvalid", 32'(bus.p0_rvalid), 1);
        check("mis_ld_rdata", bus.p0_rdata, 32'h0);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("mis_err_clear", 32'(bus.misalign_err), 0);

        // Forced cycle with port 1 withdrawn
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            check($sformatf("frc%0d_p1_gnt", i), 32'(bus.p1_gnt), 0);
        end
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h20, 32'h0);
        check("frc_state", 32'(dut.state), 32'(P1_FORCE));
        check("frc_p0_gnt", 32'(bus.p0_gnt), 0);
        check("frc_p1_gnt", 32'(bus.p1_gnt), 0);
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h20, 32'h0);
        check("frc_back_state", 32'(dut.state), 32'(P0_PRIO));
        check("frc_back_p0_gnt", 32'(bus.p0_gnt), 1);
        check("frc_count", 32'(dut.u_starve.count), 0);

        // Reset mid-stream with a store pending
        drive(1, 1, 32'h18, 32'h0000_0055, 0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_mem_we", 32'(bus.mem_we), 0);
        check("mid_rst_p0_gnt", 32'(bus.p0_gnt), 0);
        check("mid_rst_rdata0", bus.p0_rdata, 0);
        check("mid_rst_rdata1", bus.p1_rdata, 0);
        check("mid_rst_rvalid0", 32'(bus.p0_rvalid), 0);
        check("mid_rst_state", 32'(dut.state), 32'(P0_PRIO));
        @(posedge clk); #1;
        check("mid_rst_no_store", mem[6], 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        drive(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
        check("post_rst_p0_gnt", 32'(bus.p0_gnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
